uart_irq_register_set: RTL and testbench
========================================

Name: uart_irq_register_set

Overview:
16550-compatible UART register set with interrupt support. It adds IER/IIR with standard priority encoding, programmable RX trigger levels, character-timeout detection and parametrised FIFO depth. It sits between the APB register slave and the UART TX/RX serialisers, and drives a single level interrupt to the system.

Parameters:
FIFO_AW, 4, FIFO address width; depth DEPTH = 2**FIFO_AW (minimum FIFO_AW = 2)
TIMEOUT_TICKS, 40, baud_tick_i pulses without RX activity before timeout (4 chars x 10 bits)
TO_CNT_W, 8, width of timeout counter; must hold TIMEOUT_TICKS

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
reg_addr_i  in  8  register offset
reg_data_i  in  8  write data
reg_data_o  out  8  read data, registered
reg_wr_en_i  in  1  write strobe
reg_rd_en_i  in  1  read strobe
reg_wr_done_o  out  1  write done, one cycle after strobe
reg_rd_done_o  out  1  read done, one cycle after strobe
rx_fifo_wr_en_i  in  1  receiver push
rx_fifo_wr_data_i  in  10  {frame_err, parity_err, data[7:0]}
tx_fifo_rd_en_i  in  1  transmitter pop
tx_fifo_rd_data_o  out  8  TX FIFO head (first-word fall-through)
tx_fifo_rd_empty_o  out  1  TX FIFO empty
tsr_empty_i  in  1  transmit shift register empty
rsr_full_i  in  1  receive shift register full
baud_tick_i  in  1  one pulse per bit time
word_len_o  out  2  LCR[1:0]
stp_bits_o  out  1  LCR[2]
parity_en_o  out  1  LCR[3]
even_parity_sel_o  out  1  LCR[4]
baud_div_o  out  16  {DLM, DLL}
irq_o  out  1  interrupt, registered, active-high

Behaviour:
- Reset: all registers, outputs, counts and irq_o = 0. IIR reads 8'hC1. tx_fifo_rd_empty_o = 1.
- Reset mid-operation flushes both FIFOs and clears all pending interrupts.
- FIFOs: two instances of sync_fwft_fifo; reset = rst_i OR FCR clear bit.
- Occupancy counters: rx_cnt and tx_cnt, width FIFO_AW+1. +1 on accepted push, -1 on accepted pop; simultaneous push and pop leaves the count unchanged.
- Offsets 0-7 follow the 16550 map; DLAB = LCR[7].
- Offset 0, DLAB=0: write pushes THR; write when TX full is dropped.
- Offset 0, DLAB=0: read returns RBR and pops the RX FIFO. Read when RX empty returns 8'h00 with no pop.
- Offset 1, DLAB=0: IER[3:0] = {unused, RLS, THRE, RDA}. DLAB=1 selects DLM.
- Offset 2, write (FCR): bits [2:1] are one-cycle self-clearing TX/RX FIFO flushes. FCR[7:6] is stored.
- Offset 2, read (IIR): {2'b11, 2'b00, id[3:0]}.
- RX trigger level from FCR[7:6]: 00 = 1, 01 = DEPTH/4, 10 = DEPTH/2, 11 = DEPTH-2 (16-deep FIFO: 1/4/8/14).
- LSR[0] = rx_cnt != 0.
- LSR[1] overrun: set when an RX push arrives while full, or when RX is full and rsr_full_i is asserted. The push is dropped. Sticky; cleared on LSR read.
- LSR[3:2] = head error bits. LSR[7] = any error present in the RX FIFO (error counter).
- LSR[5] = TX empty. LSR[6] = TX empty AND tsr_empty_i.
- Interrupt priority, highest first (ids):
  - 0110 RLS: IER[2] AND (LSR[1] or LSR[2] or LSR[3]).
  - 0100 RDA: IER[0] AND rx_cnt >= trigger.
  - 1100 timeout: IER[0] AND to_pend.
  - 0010 THRE: IER[1] AND thre_pend.
  - 0001 none.
- Timeout counter: reloads to 0 on RX push, RBR read or RX flush. Increments on baud_tick_i while rx_cnt != 0 and to_pend = 0. Reaching TIMEOUT_TICKS sets to_pend. to_pend clears on RBR read or RX flush.
- thre_pend: set on the cycle the TX FIFO becomes empty (pop of the last entry or TX flush), or when IER[1] rises 0->1 while TX is empty. Cleared by a THR write, or by an IIR read that returns 0010.
- irq_o = registered (id != 0001); one cycle latency after the cause.
- Read and write strobes in the same cycle are both serviced. A THR write plus a same-cycle IIR read returning THRE: the clear wins.

Optional Feature:
UART_FIFO_LEVEL_EN
- Defined: read-only offsets 8'h08 = RX level and 8'h09 = TX level, each zero-extended {rx_cnt} / {tx_cnt} truncated to 8 bits. Writes are ignored.
- Undefined: those offsets read 8'h00, as do all unmapped offsets.

Decomposition:
- Package uart_reg_pkg holds:
  - register offset localparams;
  - IIR id constants;
  - trigger-encoding typedef enum logic [1:0];
  - LSR bit index constants.
- Sub-module uart_irq_ctrl holds the timeout counter, thre_pend, priority encoder and irq_o register. The register decode stays in the top level.

Test Plan:
- Reset, then read IIR, LSR, LCR -> 8'hC1, 8'h60, 8'h00; irq_o = 0.
- FCR = 8'h41 (trigger 4), IER = 8'h01, push 3 bytes -> no irq. Push a 4th -> irq_o = 1 next cycle, IIR = 8'hC4. Read RBR once -> irq_o = 0.
- IER = 8'h01, push 1 byte, drive 40 baud_tick_i pulses -> IIR = 8'hCC, irq_o = 1. RBR read -> IIR = 8'hC1.
- IER = 8'h02 with TX empty -> IIR = 8'hC2. IIR read -> next IIR read = 8'hC1. Write THR, pop it -> IIR = 8'hC2 again.
- Fill RX with DEPTH entries, push one more -> LSR[1] = 1 and RLS id 0110 outranks RDA. LSR read -> LSR[1] = 0, IIR = 8'hC4.
- DLAB = 1, write DLL = 8'h1B, DLM = 8'h00 -> baud_div_o = 16'h001B. With UART_FIFO_LEVEL_EN and 5 RX entries, offset 8 reads 8'h05.

Source files
------------

// File: rtl/uart_reg_pkg.sv
// Shared constants for the 16550-style UART register set.
// Offsets 8/9 are only decoded when UART_FIFO_LEVEL_EN is defined.
package uart_reg_pkg;

  localparam logic [7:0] OFS_RBR   = 8'h00;
  localparam logic [7:0] OFS_IER   = 8'h01;
  localparam logic [7:0] OFS_IIR   = 8'h02;
  localparam logic [7:0] OFS_LCR   = 8'h03;
  localparam logic [7:0] OFS_MCR   = 8'h04;
  localparam logic [7:0] OFS_LSR   = 8'h05;
  localparam logic [7:0] OFS_MSR   = 8'h06;
  localparam logic [7:0] OFS_SCR   = 8'h07;
  localparam logic [7:0] OFS_RXLVL = 8'h08;
  localparam logic [7:0] OFS_TXLVL = 8'h09;

  localparam logic [3:0] IID_RLS  = 4'b0110;
  localparam logic [3:0] IID_RDA  = 4'b0100;
  localparam logic [3:0] IID_TO   = 4'b1100;
  localparam logic [3:0] IID_THRE = 4'b0010;
  localparam logic [3:0] IID_NONE = 4'b0001;

  typedef enum logic [1:0] {
    TRIG_ONE  = 2'b00,
    TRIG_QTR  = 2'b01,
    TRIG_HALF = 2'b10,
    TRIG_FULL = 2'b11
  } trig_e;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_PE   = 2;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;
  localparam int LSR_ERR  = 7;

  function automatic int unsigned trig_level(
    input trig_e       t,
    input int unsigned depth
  );
    unique case (t)
      TRIG_ONE:  return 1;
      TRIG_QTR:  return depth / 4;
      TRIG_HALF: return depth / 2;
      default:   return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// Head reads as zero while empty.
module sync_fwft_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   cnt_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;

  assign full_o  = cnt_o[AW];
  assign empty_o = (cnt_o == '0);
  assign push    = wr_en_i && !full_o;
  assign pop     = rd_en_i && !empty_o;

  assign rd_data_o = empty_o ? '0 : mem[rp];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp    <= '0;
      rp    <= '0;
      cnt_o <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)
        cnt_o <= cnt_o + 1'b1;
      else if (pop && !push)
        cnt_o <= cnt_o - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= wr_data_i;
  end

endmodule

// File: rtl/uart_irq_ctrl.sv
// Interrupt side of the UART: char timeout, THRE pending,
// 16550 priority encoding and the registered irq line.
module uart_irq_ctrl
  import uart_reg_pkg::*;
#(
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned TIMEOUT_TICKS = 40,
  parameter int unsigned TO_CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       ier_i,
  input  trig_e            trig_i,
  input  logic [FIFO_AW:0] rx_cnt_i,
  input  logic             rx_push_i,
  input  logic             rbr_rd_i,
  input  logic             rx_flush_i,
  input  logic             baud_tick_i,
  input  logic             ls_err_i,
  input  logic             thre_set_i,
  input  logic             thre_clr_i,
  input  logic             iir_rd_i,
  output logic [3:0]       iid_o,
  output logic             irq_o
);

  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [CW-1:0]       trig_cnt;
  logic [TO_CNT_W-1:0] to_cnt;
  logic [TO_CNT_W-1:0] to_nxt;
  logic                to_pend;
  logic                thre_pend;

  assign trig_cnt = CW'(trig_level(trig_i, DEPTH));
  assign to_nxt   = to_cnt + 1'b1;

  always_comb begin
    iid_o = IID_NONE;
    if (ier_i[2] && ls_err_i)
      iid_o = IID_RLS;
    else if (ier_i[0] && rx_cnt_i >= trig_cnt)
      iid_o = IID_RDA;
    else if (ier_i[0] && to_pend)
      iid_o = IID_TO;
    else if (ier_i[1] && thre_pend)
      iid_o = IID_THRE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt    <= '0;
      to_pend   <= 1'b0;
      thre_pend <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      if (rx_push_i || rbr_rd_i || rx_flush_i) begin
        to_cnt <= '0;
      end else if (baud_tick_i && rx_cnt_i != '0 && !to_pend) begin
        to_cnt <= to_nxt;
        if (to_nxt == TO_CNT_W'(TIMEOUT_TICKS)) to_pend <= 1'b1;
      end
      if (rbr_rd_i || rx_flush_i) to_pend <= 1'b0;
      // a clear always beats a same-cycle set
      if (thre_clr_i || (iir_rd_i && iid_o == IID_THRE))
        thre_pend <= 1'b0;
      else if (thre_set_i)
        thre_pend <= 1'b1;
      irq_o <= (iid_o != IID_NONE);
    end
  end

endmodule

// File: rtl/uart_irq_register_set.sv
// 16550-compatible register set with FIFOs and interrupts.
// Define UART_FIFO_LEVEL_EN to expose RX/TX levels at offsets 8/9.
module uart_irq_register_set
  import uart_reg_pkg::*;
#(
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned TIMEOUT_TICKS = 40,
  parameter int unsigned TO_CNT_W      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [7:0]  reg_data_i,
  output logic [7:0]  reg_data_o,
  input  logic        reg_wr_en_i,
  input  logic        reg_rd_en_i,
  output logic        reg_wr_done_o,
  output logic        reg_rd_done_o,
  input  logic        rx_fifo_wr_en_i,
  input  logic [9:0]  rx_fifo_wr_data_i,
  input  logic        tx_fifo_rd_en_i,
  output logic [7:0]  tx_fifo_rd_data_o,
  output logic        tx_fifo_rd_empty_o,
  input  logic        tsr_empty_i,
  input  logic        rsr_full_i,
  input  logic        baud_tick_i,
  output logic [1:0]  word_len_o,
  output logic        stp_bits_o,
  output logic        parity_en_o,
  output logic        even_parity_sel_o,
  output logic [15:0] baud_div_o,
  output logic        irq_o
);

  localparam int unsigned CW = FIFO_AW + 1;

  logic [7:0]    lcr, mcr, scr, dll, dlm;
  logic [3:0]    ier;
  trig_e         trig;
  logic          rx_flush_q, tx_flush_q, oe_q;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [9:0]    rx_head;
  logic          rx_full, rx_empty, tx_full;
  logic [7:0]    lsr, rd_mux;
  logic [3:0]    iid;
  logic          dlab;
  logic          thr_wr, dll_wr, ier_wr, dlm_wr;
  logic          fcr_wr, lcr_wr, mcr_wr, scr_wr;
  logic          rbr_rd, iir_rd, lsr_rd;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic          thre_set;

  assign dlab   = lcr[7];
  assign thr_wr = reg_wr_en_i && reg_addr_i == OFS_RBR && !dlab;
  assign dll_wr = reg_wr_en_i && reg_addr_i == OFS_RBR && dlab;
  assign ier_wr = reg_wr_en_i && reg_addr_i == OFS_IER && !dlab;
  assign dlm_wr = reg_wr_en_i && reg_addr_i == OFS_IER && dlab;
  assign fcr_wr = reg_wr_en_i && reg_addr_i == OFS_IIR;
  assign lcr_wr = reg_wr_en_i && reg_addr_i == OFS_LCR;
  assign mcr_wr = reg_wr_en_i && reg_addr_i == OFS_MCR;
  assign scr_wr = reg_wr_en_i && reg_addr_i == OFS_SCR;
  assign rbr_rd = reg_rd_en_i && reg_addr_i == OFS_RBR && !dlab;
  assign iir_rd = reg_rd_en_i && reg_addr_i == OFS_IIR;
  assign lsr_rd = reg_rd_en_i && reg_addr_i == OFS_LSR;

  assign word_len_o        = lcr[1:0];
  assign stp_bits_o        = lcr[2];
  assign parity_en_o       = lcr[3];
  assign even_parity_sel_o = lcr[4];
  assign baud_div_o        = {dlm, dll};

  sync_fwft_fifo #(.DW(10), .AW(FIFO_AW)) u_rx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i || rx_flush_q),
    .wr_en_i   (rx_fifo_wr_en_i),
    .wr_data_i (rx_fifo_wr_data_i),
    .rd_en_i   (rbr_rd),
    .rd_data_o (rx_head),
    .full_o    (rx_full),
    .empty_o   (rx_empty),
    .cnt_o     (rx_cnt)
  );

  sync_fwft_fifo #(.DW(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i || tx_flush_q),
    .wr_en_i   (thr_wr),
    .wr_data_i (reg_data_i),
    .rd_en_i   (tx_fifo_rd_en_i),
    .rd_data_o (tx_fifo_rd_data_o),
    .full_o    (tx_full),
    .empty_o   (tx_fifo_rd_empty_o),
    .cnt_o     (tx_cnt)
  );

  assign rx_push = rx_fifo_wr_en_i && !rx_full;
  assign rx_pop  = rbr_rd && !rx_empty;
  assign tx_push = thr_wr && !tx_full;
  assign tx_pop  = tx_fifo_rd_en_i && !tx_fifo_rd_empty_o;

  // TX goes empty on a last-entry pop, a flush, or THRE enabled while idle
  assign thre_set = tx_flush_q
                 || (tx_pop && !tx_push && tx_cnt == CW'(1))
                 || (ier_wr && reg_data_i[1] && !ier[1] && tx_fifo_rd_empty_o);

  always_comb begin
    lsr           = '0;
    lsr[LSR_DR]   = !rx_empty;
    lsr[LSR_OE]   = oe_q;
    lsr[LSR_PE]   = rx_head[8];
    lsr[LSR_FE]   = rx_head[9];
    lsr[LSR_THRE] = tx_fifo_rd_empty_o;
    lsr[LSR_TEMT] = tx_fifo_rd_empty_o && tsr_empty_i;
    lsr[LSR_ERR]  = (err_cnt != '0);
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr_i)
      OFS_RBR: rd_mux = dlab ? dll : rx_head[7:0];
      OFS_IER: rd_mux = dlab ? dlm : {4'h0, ier};
      OFS_IIR: rd_mux = {4'b1100, iid};
      OFS_LCR: rd_mux = lcr;
      OFS_MCR: rd_mux = mcr;
      OFS_LSR: rd_mux = lsr;
      OFS_SCR: rd_mux = scr;
`ifdef UART_FIFO_LEVEL_EN
      OFS_RXLVL: rd_mux = 8'(rx_cnt);
      OFS_TXLVL: rd_mux = 8'(tx_cnt);
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || rx_flush_q) begin
      err_cnt <= '0;
    end else begin
      unique case ({rx_push && |rx_fifo_wr_data_i[9:8],
                    rx_pop && |rx_head[9:8]})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: err_cnt <= err_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lcr           <= '0;
      mcr           <= '0;
      scr           <= '0;
      dll           <= '0;
      dlm           <= '0;
      ier           <= '0;
      trig          <= TRIG_ONE;
      rx_flush_q    <= 1'b0;
      tx_flush_q    <= 1'b0;
      oe_q          <= 1'b0;
      reg_data_o    <= '0;
      reg_wr_done_o <= 1'b0;
      reg_rd_done_o <= 1'b0;
    end else begin
      rx_flush_q <= fcr_wr && reg_data_i[1];
      tx_flush_q <= fcr_wr && reg_data_i[2];
      unique case (1'b1)
        ier_wr:  ier  <= reg_data_i[3:0];
        dll_wr:  dll  <= reg_data_i;
        dlm_wr:  dlm  <= reg_data_i;
        fcr_wr:  trig <= trig_e'(reg_data_i[7:6]);
        lcr_wr:  lcr  <= reg_data_i;
        mcr_wr:  mcr  <= reg_data_i;
        scr_wr:  scr  <= reg_data_i;
        default: ;
      endcase
      if (rx_full && (rx_fifo_wr_en_i || rsr_full_i))
        oe_q <= 1'b1;
      else if (lsr_rd)
        oe_q <= 1'b0;
      reg_wr_done_o <= reg_wr_en_i;
      reg_rd_done_o <= reg_rd_en_i;
      if (reg_rd_en_i) reg_data_o <= rd_mux;
    end
  end

  uart_irq_ctrl #(
    .FIFO_AW       (FIFO_AW),
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .TO_CNT_W      (TO_CNT_W)
  ) u_irq_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ier_i       (ier[2:0]),
    .trig_i      (trig),
    .rx_cnt_i    (rx_cnt),
    .rx_push_i   (rx_fifo_wr_en_i),
    .rbr_rd_i    (rbr_rd),
    .rx_flush_i  (rx_flush_q),
    .baud_tick_i (baud_tick_i),
    .ls_err_i    (lsr[LSR_OE] || lsr[LSR_PE] || lsr[LSR_FE]),
    .thre_set_i  (thre_set),
    .thre_clr_i  (thr_wr),
    .iir_rd_i    (iir_rd),
    .iid_o       (iid),
    .irq_o       (irq_o)
  );

endmodule

// File: tb/tb_uart_irq_register_set.sv
// Directed bench for uart_irq_register_set.
// Honours UART_FIFO_LEVEL_EN for the level-register expectation.
module tb_uart_irq_register_set;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr, wdata, rdata;
  logic        wr_en, rd_en, wr_done, rd_done;
  logic        rx_wr_en;
  logic [9:0]  rx_wr_data;
  logic        tx_rd_en;
  logic [7:0]  tx_rd_data;
  logic        tx_empty;
  logic        tsr_empty, rsr_full, tick;
  logic [1:0]  word_len;
  logic        stp_bits, par_en, even_par;
  logic [15:0] baud_div;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] d;

  always #5 clk = ~clk;

  uart_irq_register_set dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .reg_addr_i        (addr),
    .reg_data_i        (wdata),
    .reg_data_o        (rdata),
    .reg_wr_en_i       (wr_en),
    .reg_rd_en_i       (rd_en),
    .reg_wr_done_o     (wr_done),
    .reg_rd_done_o     (rd_done),
    .rx_fifo_wr_en_i   (rx_wr_en),
    .rx_fifo_wr_data_i (rx_wr_data),
    .tx_fifo_rd_en_i   (tx_rd_en),
    .tx_fifo_rd_data_o (tx_rd_data),
    .tx_fifo_rd_empty_o(tx_empty),
    .tsr_empty_i       (tsr_empty),
    .rsr_full_i        (rsr_full),
    .baud_tick_i       (tick),
    .word_len_o        (word_len),
    .stp_bits_o        (stp_bits),
    .parity_en_o       (par_en),
    .even_parity_sel_o (even_par),
    .baud_div_o        (baud_div),
    .irq_o             (irq)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    addr = a; wdata = v; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    v = rdata;
  endtask

  task automatic push(input logic [9:0] v);
    @(negedge clk);
    rx_wr_en = 1'b1; rx_wr_data = v;
    @(negedge clk);
    rx_wr_en = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pop_tx();
    @(negedge clk);
    tx_rd_en = 1'b1;
    @(negedge clk);
    tx_rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wr_en = 0; rd_en = 0;
    rx_wr_en = 0; rx_wr_data = '0; tx_rd_en = 0;
    tsr_empty = 1'b1; rsr_full = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_irq", irq, 0);
    check("rst_txempty", tx_empty, 1);
    check("rst_baud", baud_div, 0);
    rd(8'h02, d); check("rst_iir", d, 8'hC1);
    check("rd_done", rd_done, 1);
    rd(8'h05, d); check("rst_lsr", d, 8'h60);
    rd(8'h03, d); check("rst_lcr", d, 8'h00);

    // RDA at trigger level 4
    wr(8'h02, 8'h41);
    check("wr_done", wr_done, 1);
    wr(8'h01, 8'h01);
    push(10'h011); push(10'h022); push(10'h033);
    @(negedge clk);
    check("rda_3_irq", irq, 0);
    push(10'h044);
    check("rda_lat_irq", irq, 0);
    @(negedge clk);
    check("rda_irq", irq, 1);
    rd(8'h02, d); check("rda_iir", d, 8'hC4);
    rd(8'h00, d); check("rbr_head", d, 8'h11);
    @(negedge clk);
    check("rda_clr_irq", irq, 0);

    // character timeout
    wr(8'h02, 8'h43);
    @(negedge clk);
    rd(8'h05, d); check("flush_lsr", d, 8'h60);
    push(10'h05A);
    repeat (39) pulse_tick();
    rd(8'h02, d); check("to_39_iir", d, 8'hC1);
    pulse_tick();
    rd(8'h02, d); check("to_iir", d, 8'hCC);
    check("to_irq", irq, 1);
    rd(8'h00, d); check("to_rbr", d, 8'h5A);
    rd(8'h02, d); check("to_clr_iir", d, 8'hC1);
    rd(8'h00, d); check("rbr_empty", d, 8'h00);

    // THRE
    wr(8'h01, 8'h02);
    rd(8'h02, d); check("thre_iir", d, 8'hC2);
    rd(8'h02, d); check("thre_rdclr", d, 8'hC1);
    wr(8'h00, 8'hA5);
    check("thr_empty", tx_empty, 0);
    check("thr_head", tx_rd_data, 8'hA5);
    rd(8'h05, d); check("thr_lsr", d, 8'h00);
    pop_tx();
    check("pop_empty", tx_empty, 1);
    rd(8'h02, d); check("thre_again", d, 8'hC2);
    wr(8'h00, 8'h3C);
    rd(8'h02, d); check("thre_wrclr", d, 8'hC1);
    pop_tx();

    // overrun outranks RDA
    wr(8'h01, 8'h05);
    for (int i = 0; i < 16; i++) push(10'(i));
    rd(8'h02, d); check("full_iir", d, 8'hC4);
    push(10'h0EE);
    rd(8'h02, d); check("oe_iir", d, 8'hC6);
    rd(8'h05, d); check("oe_lsr", d, 8'h63);
    rd(8'h05, d); check("oe_clr_lsr", d, 8'h61);
    rd(8'h02, d); check("oe_clr_iir", d, 8'hC4);
    rd(8'h00, d); check("oe_head", d, 8'h00);

    // rsr_full with a full FIFO also overruns
    push(10'h0F0);
    rsr_full = 1'b1;
    @(negedge clk);
    rsr_full = 1'b0;
    rd(8'h05, d); check("rsr_oe_lsr", d, 8'h63);

    // head error bits and error summary
    wr(8'h02, 8'h43);
    @(negedge clk);
    push(10'h1AA);
    rd(8'h05, d); check("pe_lsr", d, 8'hE5);
    rd(8'h02, d); check("pe_iir", d, 8'hC6);
    rd(8'h00, d); check("pe_rbr", d, 8'hAA);
    rd(8'h05, d); check("pe_clr_lsr", d, 8'h60);
    push(10'h255); push(10'h066);
    rd(8'h05, d); check("fe_lsr", d, 8'hE9);
    rd(8'h00, d);
    rd(8'h05, d); check("err_gone", d, 8'h61);
    rd(8'h00, d);

    // divisor latch and line control
    wr(8'h03, 8'h80);
    wr(8'h00, 8'h1B);
    wr(8'h01, 8'h00);
    check("baud_div", baud_div, 16'h001B);
    rd(8'h00, d); check("dll_rd", d, 8'h1B);
    wr(8'h03, 8'h1B);
    check("word_len", word_len, 2'b11);
    check("stp_bits", stp_bits, 0);
    check("par_en", par_en, 1);
    check("even_par", even_par, 1);
    rd(8'h03, d); check("lcr_rd", d, 8'h1B);

    // level registers / unmapped offsets
    for (int i = 0; i < 5; i++) push(10'(8'h30 + i));
`ifdef UART_FIFO_LEVEL_EN
    rd(8'h08, d); check("rx_lvl", d, 8'h05);
`else
    rd(8'h08, d); check("rx_lvl", d, 8'h00);
`endif
    rd(8'h0A, d); check("unmapped", d, 8'h00);
    wr(8'h02, 8'h43);
    @(negedge clk);

    // TX full drops extra writes
    for (int i = 0; i < 17; i++) wr(8'h00, 8'(8'h80 + i));
    for (int i = 0; i < 16; i++) begin
      check("tx_seq", tx_rd_data, 16'(8'h80 + i));
      pop_tx();
    end
    check("tx_drop_empty", tx_empty, 1);

    // reset mid-operation
    push(10'h011); wr(8'h00, 8'h22);
    wr(8'h01, 8'h07);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_txempty", tx_empty, 1);
    check("mid_irq", irq, 0);
    check("mid_baud", baud_div, 0);
    rd(8'h05, d); check("mid_lsr", d, 8'h60);
    rd(8'h02, d); check("mid_iir", d, 8'hC1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
